// File: rtl/game_display_sched.sv
// Display/LED arbiter between the classic and infinity game engines.
// Locks the grant to one game until it ends, then optionally shows its blinking final score.
module game_display_sched #(
  parameter int unsigned HOLD_CYCLES  = 300_000_000,
  parameter int unsigned BLINK_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  mode,
  input  logic        enable_game_classic,
  input  logic        enable_game_infinity,
  input  logic [15:0] seg_classic,
  input  logic [15:0] seg_infinity,
  input  logic [15:0] led_classic,
  input  logic [15:0] led_infinity,
  input  logic [4:0]  score_classic,
  input  logic [4:0]  score_infinity,
  input  logic        ack,
  output logic [15:0] seg_display,
  output logic        seg_blank,
  output logic [15:0] led,
  output logic [1:0]  grant,
  output logic        result_active
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_CLASSIC, S_INFINITY, S_RESULT} state_t;

  state_t      state_q, state_d;
  logic [4:0]  score_q, score_d;
  logic [HW-1:0] hold_q;
  logic [BW-1:0] blink_q;
  logic [15:0] seg_q, led_q;
  logic [1:0]  grant_q;
  logic        blank_q, result_q;
  logic        hold_done, blink_done;
  logic [15:0] bar_c, bar_i;

  // Level n in 1..16 lights the top n LEDs; anything else lights none.
  function automatic logic [15:0] bar(input logic [15:0] n);
    if (n >= 16'd1 && n <= 16'd16) return ~(16'hFFFF >> n);
    return '0;
  endfunction

  assign bar_c      = bar(led_classic);
  assign bar_i      = bar(led_infinity);
  assign hold_done  = (hold_q == HW'(HOLD_CYCLES - 1));
  assign blink_done = (blink_q == BW'(BLINK_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable_game_classic)       state_d = S_CLASSIC;
        else if (enable_game_infinity) state_d = S_INFINITY;
      end
      S_CLASSIC: begin
        if (!enable_game_classic) begin
          score_d = score_classic;
          state_d = (mode == 3'd3) ? S_RESULT : S_IDLE;
        end
      end
      S_INFINITY: begin
        if (!enable_game_infinity) begin
          score_d = score_infinity;
          state_d = (mode == 3'd3) ? S_RESULT : S_IDLE;
        end
      end
      S_RESULT: begin
        if (enable_game_classic)       state_d = S_CLASSIC;
        else if (enable_game_infinity) state_d = S_INFINITY;
        else if (ack || hold_done)     state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they appear on the same edge as the transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      score_q  <= '0;
      hold_q   <= '0;
      blink_q  <= '0;
      seg_q    <= '0;
      led_q    <= '0;
      grant_q  <= '0;
      blank_q  <= 1'b0;
      result_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      hold_q   <= '0;
      blink_q  <= '0;
      seg_q    <= '0;
      led_q    <= '0;
      grant_q  <= '0;
      blank_q  <= 1'b0;
      result_q <= 1'b0;
      unique case (state_d)
        S_CLASSIC: begin
          grant_q <= 2'b01;
          seg_q   <= seg_classic;
          led_q   <= bar_c;
        end
        S_INFINITY: begin
          grant_q <= 2'b10;
          seg_q   <= seg_infinity;
          led_q   <= bar_i;
        end
        S_RESULT: begin
          result_q <= 1'b1;
          seg_q    <= {11'b0, score_d};
          if (state_q == S_RESULT) begin
            hold_q <= hold_q + HW'(1);
            if (blink_done) begin
              blink_q <= '0;
              blank_q <= ~blank_q;
            end else begin
              blink_q <= blink_q + BW'(1);
              blank_q <= blank_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign seg_display   = seg_q;
  assign seg_blank     = blank_q;
  assign led           = led_q;
  assign grant         = grant_q;
  assign result_active = result_q;

endmodule

// File: tb/tb_game_display_sched.sv
// Directed self-checking bench for game_display_sched with short hold/blink periods.
module tb_game_display_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  mode;
  logic        en_c, en_i, ack;
  logic [15:0] seg_c, seg_i, led_c, led_i;
  logic [4:0]  sc_c, sc_i;
  logic [15:0] seg_display, led;
  logic        seg_blank, result_active;
  logic [1:0]  grant;

  int unsigned pass_cnt = 0;
  int unsigned total    = 0;

  always #5 clk = ~clk;

  game_display_sched #(.HOLD_CYCLES(20), .BLINK_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .enable_game_classic(en_c), .enable_game_infinity(en_i),
    .seg_classic(seg_c), .seg_infinity(seg_i),
    .led_classic(led_c), .led_infinity(led_i),
    .score_classic(sc_c), .score_infinity(sc_i), .ack(ack),
    .seg_display(seg_display), .seg_blank(seg_blank), .led(led),
    .grant(grant), .result_active(result_active)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_seg"}, 32'(seg_display), 32'd0);
    check({tag, "_led"}, 32'(led), 32'd0);
    check({tag, "_blank"}, 32'(seg_blank), 32'd0);
    check({tag, "_res"}, 32'(result_active), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; mode = 3'd0; en_c = 1'b0; en_i = 1'b0; ack = 1'b0;
    seg_c = '0; seg_i = '0; led_c = '0; led_i = '0; sc_c = '0; sc_i = '0;
    tick(); tick();
    check_idle("rst");
    rst_n = 1'b1;
    tick(); tick();
    check_idle("idle_after_rst");

    // Classic grant and bar mapping
    seg_c = 16'd1234; led_c = 16'd5; en_c = 1'b1;
    tick();
    check("c_grant", 32'(grant), 32'd1);
    check("c_seg", 32'(seg_display), 32'd1234);
    check("c_led5", 32'(led), 32'hF800);
    led_c = 16'd17; ack = 1'b1;
    tick();
    ack = 1'b0;
    check("c_led17", 32'(led), 32'h0000);
    check("c_ack_ignored", 32'(grant), 32'd1);

    // Grant lock, then owner ends with mode!=3 while infinity waits
    en_i = 1'b1; seg_i = 16'hBEEF; led_i = 16'd2;
    tick();
    check("lock_grant", 32'(grant), 32'd1);
    check("lock_seg", 32'(seg_display), 32'd1234);
    mode = 3'd2; en_c = 1'b0;
    tick();
    check_idle("c_end_idle");
    tick();
    check("i_grant", 32'(grant), 32'd2);
    check("i_seg", 32'(seg_display), 32'hBEEF);
    check("i_led2", 32'(led), 32'hC000);
    mode = 3'd0; en_i = 1'b0;
    tick();
    check_idle("i_end_idle");

    // Simultaneous start: classic wins
    en_c = 1'b1; en_i = 1'b1;
    tick();
    check("both_grant", 32'(grant), 32'd1);
    en_i = 1'b0;
    tick();

    // Result with timeout and blink
    mode = 3'd3; sc_c = 5'd19; en_c = 1'b0;
    tick();
    check("r_active", 32'(result_active), 32'd1);
    check("r_seg", 32'(seg_display), 32'd19);
    check("r_blank0", 32'(seg_blank), 32'd0);
    check("r_grant", 32'(grant), 32'd0);
    check("r_led", 32'(led), 32'd0);
    mode = 3'd1;
    for (int k = 1; k < 20; k++) begin
      tick();
      check($sformatf("r_blank_%0d", k), 32'(seg_blank), 32'((k / 4) % 2));
      check($sformatf("r_act_%0d", k), 32'(result_active), 32'd1);
    end
    check("r_seg_late", 32'(seg_display), 32'd19);
    tick();
    check_idle("r_timeout");

    // Zero score, early exit via ack
    en_c = 1'b1; sc_c = 5'd0; mode = 3'd3;
    tick();
    en_c = 1'b0;
    tick();
    check("z_active", 32'(result_active), 32'd1);
    check("z_seg", 32'(seg_display), 32'd0);
    tick(); tick();
    check("z_still", 32'(result_active), 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_idle("z_ack");

    // Infinity bar extremes and preemption of RESULT
    en_i = 1'b1; led_i = 16'd16; seg_i = 16'd42;
    tick();
    check("i_led16", 32'(led), 32'hFFFF);
    led_i = 16'd1;
    tick();
    check("i_led1", 32'(led), 32'h8000);
    led_i = 16'd0;
    tick();
    check("i_led0", 32'(led), 32'h0000);
    sc_i = 5'd7; en_i = 1'b0;
    tick();
    check("ir_seg", 32'(seg_display), 32'd7);
    check("ir_active", 32'(result_active), 32'd1);
    for (int k = 0; k < 5; k++) tick();
    check("ir_blank", 32'(seg_blank), 32'd1);
    en_i = 1'b1; ack = 1'b1;
    tick();
    ack = 1'b0;
    check("pre_grant", 32'(grant), 32'd2);
    check("pre_blank", 32'(seg_blank), 32'd0);
    check("pre_active", 32'(result_active), 32'd0);
    check("pre_seg", 32'(seg_display), 32'd42);

    // Asynchronous reset mid-game
    led_i = 16'd3;
    tick();
    check("pre_rst_led", 32'(led), 32'hE000);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    en_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check_idle("post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/game_display_sched.md
Name: game_display_sched

Overview:
- Owns the shared 4-digit seven-segment display and the 16-LED bar.
- Grants the display to exactly one game engine (classic or infinity) at a time and locks the grant until that game ends.
- After a game ends in result mode, it shows that game's final score, blinking, for a bounded time.
- Sits between the two game engines and the seg7decimal driver / LED pins; its seg_display output feeds the decimal driver's data input directly.

Parameters:
- HOLD_CYCLES, 300_000_000: clk cycles the final score stays up in RESULT (3 s at 100 MHz).
- BLINK_CYCLES, 50_000_000: clk cycles per blink half-period in RESULT.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mode  in  3  menu mode; value 3 = show final result after a game
- enable_game_classic  in  1  classic game running (level)
- enable_game_infinity  in  1  infinity game running (level)
- seg_classic  in  16  classic display value
- seg_infinity  in  16  infinity display value
- led_classic  in  16  classic LED level, 0..16
- led_infinity  in  16  infinity LED level, 0..16
- score_classic  in  5  classic final score
- score_infinity  in  5  infinity final score
- ack  in  1  one-cycle pulse (debounced button); exits RESULT early
- seg_display  out  16  value to seg7decimal data
- seg_blank  out  1  1 = driver blanks digits
- led  out  16  LED bar
- grant  out  2  01 = classic, 10 = infinity, 00 = none
- result_active  out  1  high while in RESULT

Behaviour:
- States: IDLE, CLASSIC, INFINITY, RESULT. All outputs are registered.
- Reset (async, rst_n=0): state IDLE. seg_display, led, grant, seg_blank, result_active, hold counter, blink counter and score_reg all cleared to 0. Release is sampled on the next clk edge.
- IDLE:
  - Outputs all zero.
  - enable_game_classic=1 -> CLASSIC. This takes priority when both enables rise in the same cycle.
  - Else enable_game_infinity=1 -> INFINITY.
- CLASSIC:
  - grant=01; seg_display<=seg_classic; led<=bar(led_classic). One-cycle latency from input to output.
  - enable_game_infinity is ignored while here (grant locked).
  - On the first cycle enable_game_classic=0: score_reg<=score_classic. Next state is RESULT if mode==3, else IDLE.
- INFINITY: symmetric to CLASSIC, using grant=10 and the infinity inputs.
- bar(n):
  - n in 1..16 -> top n bits set, filled from led[15] downward (n=1 -> 16'h8000, n=16 -> 16'hFFFF).
  - n=0 or n>16 -> 16'h0000.
- RESULT:
  - grant=00; result_active=1; led=0; seg_display={11'b0, score_reg}.
  - On entry, hold and blink counters are cleared and seg_blank=0 (score visible).
  - seg_blank toggles each time the blink counter reaches BLINK_CYCLES-1; the counter then reloads 0.
  - Exit to IDLE when the hold counter reaches HOLD_CYCLES-1, or on ack=1.
  - Any enable takes precedence over ack or timeout in the same cycle: go directly to CLASSIC (classic priority) or INFINITY, and clear seg_blank and result_active.
- Simultaneous events:
  - The owning game's enable falls in the same cycle the other game's enable is high: the owner still transitions to RESULT/IDLE.
  - The other game is granted from RESULT/IDLE on the following cycle.
- A score_reg of 0 is displayed as 0; a zero score still enters RESULT.
- mode is sampled only on the end-of-game cycle; later changes to mode do not affect RESULT.
- ack outside RESULT has no effect.

Test Plan:
- Reset behaviour: rst_n=0 mid-INFINITY with outputs nonzero -> same cycle, all outputs 0 and grant=00. After release with no enables, remains in IDLE.
- Classic grant path: HOLD=20, BLINK=4; assert enable_game_classic, seg_classic=16'd1234, led_classic=5 -> one cycle later grant=01, seg_display=1234, led=16'hF800. led_classic=17 -> led=0.
- Simultaneous start and grant lock: both enables rise together -> grant=01. While classic runs, infinity inputs do not appear. Drop classic with mode=2 -> IDLE, then grant=10 one cycle later.
- Result timeout and blink: mode=3, score_classic=19, drop enable_classic -> result_active=1, seg_display=19, seg_blank toggles every 4 cycles. After 20 cycles -> IDLE, all outputs 0.
- Result early exit and preemption:
  - ack pulse at RESULT cycle 3 -> IDLE next cycle.
  - Separate run: enable_game_infinity and ack asserted together in RESULT -> INFINITY (grant=10), seg_blank=0.
- Infinity bar extremes: led_infinity=16 -> led=16'hFFFF; led_infinity=1 -> led=16'h8000; led_infinity=0 -> led=0.
